// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and one-bubble next-PC redirect.
// Optional macro BRANCH_DELAY_SLOT_EN: keep the sequential instruction on redirect instead of flushing.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        BranchEQ,
  input  logic        BranchNE,
  input  logic        jump,
  input  logic        jal,
  input  logic        jr,
  input  logic        zero,
  input  logic [31:0] jr_target,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic [31:0] link_addr,
  output logic        redirect
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        id_valid_q, id_valid_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] br_off_s;
  logic [31:0] target_s;
  logic        taken_s;
  logic        redirect_s;

  // Transfer resolution and target selection for the instruction held in ID.
  always_comb begin
    pc_plus4_s = pc_q + 32'd4;
    br_off_s   = {{14{id_instr_q[15]}}, id_instr_q[15:0], 2'b00};
    taken_s    = id_valid_q & (jump | jr | (BranchEQ & zero) | (BranchNE & ~zero));
    redirect_s = taken_s & ~stall;
    if (jr) begin
      target_s = jr_target & 32'hFFFF_FFFC;
    end else if (jump | jal) begin
      target_s = {id_pc_plus4_q[31:28], id_instr_q[25:0], 2'b00};
    end else begin
      target_s = id_pc_plus4_q + br_off_s;
    end
  end

  // Next-state for PC and IF/ID; a stall freezes everything.
  always_comb begin
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    if (!stall) begin
      if (redirect_s) begin
        pc_d = target_s;
`ifdef BRANCH_DELAY_SLOT_EN
        id_instr_d    = imem_rdata;
        id_pc_plus4_d = pc_plus4_s;
        id_valid_d    = 1'b1;
`else
        id_instr_d    = 32'h0000_0000;
        id_pc_plus4_d = 32'h0000_0000;
        id_valid_d    = 1'b0;
`endif
      end else begin
        pc_d          = pc_plus4_s;
        id_instr_d    = imem_rdata;
        id_pc_plus4_d = pc_plus4_s;
        id_valid_d    = 1'b1;
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      id_instr_q    <= 32'h0000_0000;
      id_pc_plus4_q <= 32'h0000_0000;
      id_valid_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
    end
  end

  // Output mapping; with a delay slot the return address skips the slot instruction.
  always_comb begin
    imem_addr   = pc_q;
    id_instr    = id_instr_q;
    id_pc_plus4 = id_pc_plus4_q;
    id_valid    = id_valid_q;
    redirect    = redirect_s;
`ifdef BRANCH_DELAY_SLOT_EN
    link_addr   = id_pc_plus4_q + 32'd4;
`else
    link_addr   = id_pc_plus4_q;
`endif
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the MIPS core. Holds the PC, drives instruction-memory address, and captures the fetched word plus PC+4 for the decode stage. It consumes the decode-stage control outputs (BranchEQ, BranchNE, jump, jal, jr) together with the register-compare result, and resolves next-PC with a one-bubble redirect.

## Interface
- RESET_PC, 32'h0040_0000, PC value loaded on reset (text segment base)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- stall  input  1  hold PC and IF/ID register this cycle
- imem_addr  output  32  current PC, to instruction memory
- imem_rdata  input  32  instruction at imem_addr, combinational read, same cycle
- BranchEQ, BranchNE, jump, jal, jr  input  1 each  control for the instruction currently in ID
- zero  input  1  ID-stage compare, 1 when rs == rt
- jr_target  input  32  rs register value for jr
- id_instr  output  32  instruction in ID (32'h0000_0000 NOP when bubble)
- id_pc_plus4  output  32  PC+4 of instruction in ID
- id_valid  output  1  ID holds a real instruction
- link_addr  output  32  return address for jal
- redirect  output  1  control transfer taken and accepted this cycle

## Operation
- Registers: pc, id_instr, id_pc_plus4, id_valid.
- taken = id_valid & (jump | jr | (BranchEQ & zero) | (BranchNE & ~zero)); control inputs ignored when id_valid=0.
- redirect = taken & ~stall.
- Target priority: jr > jump/jal > branch.
  - jr: {jr_target[31:2], 2'b00}; low two bits always cleared.
  - jump/jal: {id_pc_plus4[31:28], id_instr[25:0], 2'b00}.
  - branch: id_pc_plus4 + {sign-extend(id_instr[15:0]), 2'b00}, modulo 2^32.
- next_pc = redirect ? target : pc + 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
- Each non-stalled edge: pc <= next_pc.
  - No redirect: id_instr <= imem_rdata, id_pc_plus4 <= pc+4, id_valid <= 1.
  - Redirect: IF/ID loaded per Configuration.
- stall=1: pc, id_instr, id_pc_plus4, id_valid all hold. redirect forced 0; taken is re-evaluated on the following cycle because the ID instruction is unchanged.
- link_addr = id_pc_plus4 (+4 when delay slot enabled); valid only while jal=1.

## Timing
- Reset (asynchronous assert, any cycle, including mid-redirect): pc=RESET_PC, id_instr=0, id_valid=0, id_pc_plus4=0. Hence redirect=0, link_addr=0 (or 4 with delay slot), imem_addr=RESET_PC.
- First edge after reset release: ID receives the instruction at RESET_PC with id_valid=1.
- Fetch latency: an instruction presented at cycle N appears in ID at cycle N+1.
- Taken transfer decoded in ID at cycle N:
  - redirect=1 during N.
  - imem_addr=target in N+1.
  - Target instruction in ID in N+2.
  - Penalty is one bubble without delay slot.
- stall and taken together: stall wins; no state change and no redirect until stall=0.
- Back-to-back transfers: a bubble in ID (id_valid=0) can never redirect. A transfer in the delay slot (when enabled) redirects normally.

## Configuration
- BRANCH_DELAY_SLOT_EN defined:
  - On redirect, IF/ID captures the already-fetched sequential instruction (imem_rdata, pc+4, id_valid=1). That instruction executes; no bubble.
  - link_addr = id_pc_plus4 + 4.
- Undefined (default):
  - On redirect, IF/ID is flushed: id_instr=0, id_valid=0, id_pc_plus4=0.
  - link_addr = id_pc_plus4.

## Test plan
- Reset sequence: hold reset=0 for 3 cycles, then release with imem returning 32'h2008_0005 at 0x0040_0000 -> imem_addr=0x0040_0000 during reset. Next edge: id_instr=32'h2008_0005, id_valid=1, id_pc_plus4=0x0040_0004, imem_addr=0x0040_0004.
- BEQ taken: ID holds beq at 0x0040_0010 (imm=16'h0003), BranchEQ=1, zero=1 -> redirect=1, next imem_addr=0x0040_0020. ID bubble (id_valid=0) without delay slot; ID=instruction at 0x0040_0014 with delay slot. BNE with zero=1 -> no redirect, PC+4.
- Negative branch offset: imm=16'hFFFF at PC 0x0040_0010 -> target 0x0040_0010.
- jal then jr: jal with target field 26'h010_0008 at 0x0040_0000 -> imem_addr=0x0040_0020, link_addr=0x0040_0004 (0x0040_0008 with delay slot). jr with jr_target=0x0040_0007 -> imem_addr=0x0040_0004.
- Stall over a taken branch for 2 cycles -> pc, ID, and redirect all held at 0. Redirect asserts in the cycle stall drops, then resumes as in the BEQ case.
- PC wrap: force pc=32'hFFFF_FFFC, no transfer -> next imem_addr=0, id_pc_plus4=0.
